// File: rtl/dyn_disp_pkg.sv
// Shared constants and encodings for the dynamic display timing path.
// Default prescaler geometry and count direction.
package dyn_disp_pkg;

  localparam int unsigned DISP_WIDTH       = 23;
  localparam int unsigned DISP_DEFAULT_MOD = 5000000;
  localparam int unsigned DISP_STG_W       = 3;
  localparam int unsigned DISP_STG_MOD     = 8;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/dyn_mod_shadow.sv
// Modulus shadow register: holds a requested period until the
// prescaler reaches a safe point (wrap or clear) and then applies it.
module dyn_mod_shadow
  import dyn_disp_pkg::*;
#(
  parameter int unsigned WIDTH       = DISP_WIDTH,
  parameter int unsigned DEFAULT_MOD = DISP_DEFAULT_MOD
) (
  input  logic             pixel_clk,
  input  logic             reset,
  input  logic             mod_wr,
  input  logic [WIDTH-1:0] mod_in,
  input  logic             apply,
  output logic [WIDTH-1:0] mod_cur,
  output logic [WIDTH-1:0] mod_nxt
);

  logic [WIDTH-1:0] shadow;
  logic             pending;
  logic             wr_ok;

  assign wr_ok = mod_wr && (mod_in != '0);

  // A write landing on the apply cycle wins over an older shadow.
  always_comb begin
    mod_nxt = mod_cur;
    if (wr_ok)
      mod_nxt = mod_in;
    else if (pending)
      mod_nxt = shadow;
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      shadow  <= '0;
      pending <= 1'b0;
      mod_cur <= WIDTH'(DEFAULT_MOD);
    end else if (apply) begin
      mod_cur <= mod_nxt;
      pending <= 1'b0;
    end else if (wr_ok) begin
      shadow  <= mod_in;
      pending <= 1'b1;
    end
  end

endmodule

// File: rtl/dyn_prescale_counter.sv
// Runtime-programmable up/down prescaler producing a one-cycle tick,
// with a cascaded stage counter advanced once per tick.
module dyn_prescale_counter
  import dyn_disp_pkg::*;
#(
  parameter int unsigned WIDTH       = DISP_WIDTH,
  parameter int unsigned DEFAULT_MOD = DISP_DEFAULT_MOD,
  parameter int unsigned STG_W       = DISP_STG_W,
  parameter int unsigned STG_MOD     = DISP_STG_MOD
) (
  input  logic             pixel_clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             dir_down,
  input  logic             mod_wr,
  input  logic [WIDTH-1:0] mod_in,
  output logic [WIDTH-1:0] cnt,
  output logic             tick,
  output logic [STG_W-1:0] stage_cnt,
  output logic             stage_wrap,
  output logic [WIDTH-1:0] mod_cur
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(STG_MOD - 1);

  logic             down;
  logic             wrap;
  logic             apply;
  logic [WIDTH-1:0] mod_nxt;
  logic [WIDTH-1:0] end_val;
  logic [WIDTH-1:0] reload;

  assign down    = (dir_e'(dir_down) == DIR_DOWN);
  assign end_val = down ? '0 : (mod_cur - ONE);
  assign wrap    = en && !clr && (cnt == end_val);
  assign apply   = wrap || clr;
  // Reload follows the modulus taking effect on this cycle.
  assign reload  = down ? (mod_nxt - ONE) : '0;

  dyn_mod_shadow #(
    .WIDTH       (WIDTH),
    .DEFAULT_MOD (DEFAULT_MOD)
  ) u_shadow (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .mod_wr    (mod_wr),
    .mod_in    (mod_in),
    .apply     (apply),
    .mod_cur   (mod_cur),
    .mod_nxt   (mod_nxt)
  );

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= wrap;
      if (apply)
        cnt <= reload;
      else if (en)
        cnt <= down ? (cnt - ONE) : (cnt + ONE);
    end
  end

  always_ff @(posedge pixel_clk or posedge reset) begin
    if (reset) begin
      stage_cnt  <= '0;
      stage_wrap <= 1'b0;
    end else begin
      stage_wrap <= wrap && (stage_cnt == STG_LAST);
      if (wrap)
        stage_cnt <= (stage_cnt == STG_LAST) ? '0 : (stage_cnt + 1'b1);
    end
  end

endmodule

// File: tb/tb_dyn_prescale_counter.sv
// Self-checking bench for dyn_prescale_counter with a period-level
// reference model and directed plus randomized scenarios.
module tb_dyn_prescale_counter;

  localparam int W  = 23;
  localparam int SW = 3;
  localparam int DM = 5;
  localparam int SM = 4;

  logic          pixel_clk = 1'b0;
  logic          reset;
  logic          en;
  logic          clr;
  logic          dir_down;
  logic          mod_wr;
  logic [W-1:0]  mod_in;
  logic [W-1:0]  cnt;
  logic          tick;
  logic [SW-1:0] stage_cnt;
  logic          stage_wrap;
  logic [W-1:0]  mod_cur;

  int total = 0;
  int bad   = 0;

  int m_cnt, m_mod, m_shadow, m_stage;
  bit m_pend, m_tick, m_swrap;

  always #5 pixel_clk = ~pixel_clk;

  dyn_prescale_counter #(
    .WIDTH       (W),
    .DEFAULT_MOD (DM),
    .STG_W       (SW),
    .STG_MOD     (SM)
  ) dut (
    .pixel_clk  (pixel_clk),
    .reset      (reset),
    .en         (en),
    .clr        (clr),
    .dir_down   (dir_down),
    .mod_wr     (mod_wr),
    .mod_in     (mod_in),
    .cnt        (cnt),
    .tick       (tick),
    .stage_cnt  (stage_cnt),
    .stage_wrap (stage_wrap),
    .mod_cur    (mod_cur)
  );

  task automatic model_reset();
    m_cnt = 0; m_mod = DM; m_shadow = 0; m_stage = 0;
    m_pend = 0; m_tick = 0; m_swrap = 0;
  endtask

  // Advance the reference by one period position, then clock the DUT.
  task automatic step();
    bit wrap;
    int nm;
    int mi;
    mi = int'(mod_in);
    wrap = en && !clr && (dir_down ? (m_cnt == 0) : (m_cnt == m_mod - 1));
    nm = m_mod;
    if (wrap || clr) begin
      if (mod_wr && mi != 0) nm = mi;
      else if (m_pend) nm = m_shadow;
      m_pend = 0;
    end else if (mod_wr && mi != 0) begin
      m_shadow = mi;
      m_pend = 1;
    end
    if (wrap || clr) m_cnt = dir_down ? nm - 1 : 0;
    else if (en) m_cnt = dir_down ? m_cnt - 1 : m_cnt + 1;
    m_tick = wrap;
    m_swrap = wrap && (m_stage == SM - 1);
    if (wrap) m_stage = (m_stage + 1) % SM;
    m_mod = nm;
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    en = 0; clr = 0; dir_down = 0; mod_wr = 0; mod_in = '0;
    repeat (2) @(posedge pixel_clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    en = 0; clr = 0; dir_down = 0; mod_wr = 0; mod_in = '0;
    repeat (2) @(posedge pixel_clk);
    #1;
    total++;
    if (cnt !== '0 || tick !== 1'b0 || stage_cnt !== '0 ||
        stage_wrap !== 1'b0 || mod_cur !== W'(DM)) begin
      bad++;
      $display("FAIL reset got cnt=%0d tick=%b stg=%0d sw=%b mod=%0d want 0 0 0 0 %0d",
               cnt, tick, stage_cnt, stage_wrap, mod_cur, DM);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_up_count();
    do_reset();
    en = 1;
    for (int k = 1; k <= 20; k++) begin
      step();
      total++;
      if (cnt !== W'(k % 5) || tick !== (k % 5 == 0) ||
          stage_cnt !== SW'((k / 5) % SM) || stage_wrap !== (k == 20) ||
          mod_cur !== W'(5)) begin
        bad++;
        $display("FAIL up_count k=%0d got cnt=%0d tick=%b stg=%0d sw=%b mod=%0d want %0d %b %0d %b 5",
                 k, cnt, tick, stage_cnt, stage_wrap, mod_cur,
                 k % 5, k % 5 == 0, (k / 5) % SM, k == 20);
      end
    end
  endtask

  task automatic test_mod_update();
    int exp_c[8] = '{2, 3, 4, 0, 1, 2, 0, 1};
    int exp_m[8] = '{5, 5, 5, 3, 3, 3, 3, 3};
    do_reset();
    en = 1;
    step();
    mod_wr = 1; mod_in = W'(3);
    for (int i = 0; i < 8; i++) begin
      step();
      mod_wr = 0; mod_in = '0;
      total++;
      if (cnt !== W'(exp_c[i]) || mod_cur !== W'(exp_m[i]) ||
          tick !== (exp_c[i] == 0)) begin
        bad++;
        $display("FAIL mod_update i=%0d got cnt=%0d mod=%0d tick=%b want %0d %0d %b",
                 i, cnt, mod_cur, tick, exp_c[i], exp_m[i], exp_c[i] == 0);
      end
    end
  endtask

  task automatic test_down();
    int exp_c[7] = '{4, 3, 2, 1, 0, 4, 3};
    do_reset();
    en = 1; dir_down = 1;
    for (int i = 0; i < 7; i++) begin
      step();
      total++;
      if (cnt !== W'(exp_c[i]) || tick !== (i == 0 || i == 5)) begin
        bad++;
        $display("FAIL down i=%0d got cnt=%0d tick=%b want %0d %b",
                 i, cnt, tick, exp_c[i], i == 0 || i == 5);
      end
    end
    dir_down = 0;
  endtask

  task automatic test_hold_clr();
    do_reset();
    en = 1;
    repeat (2) step();
    en = 0; mod_wr = 1; mod_in = W'(7);
    for (int i = 0; i < 3; i++) begin
      step();
      mod_wr = 0; mod_in = '0;
      total++;
      if (cnt !== W'(2) || tick !== 1'b0 || mod_cur !== W'(5)) begin
        bad++;
        $display("FAIL hold i=%0d got cnt=%0d tick=%b mod=%0d want 2 0 5",
                 i, cnt, tick, mod_cur);
      end
    end
    en = 1;
    step();
    clr = 1;
    step();
    clr = 0;
    total++;
    if (cnt !== '0 || tick !== 1'b0 || mod_cur !== W'(7) || stage_cnt !== '0) begin
      bad++;
      $display("FAIL clr got cnt=%0d tick=%b mod=%0d stg=%0d want 0 0 7 0",
               cnt, tick, mod_cur, stage_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1;
    repeat (13) step();
    total++;
    if (cnt !== W'(3) || stage_cnt !== SW'(2)) begin
      bad++;
      $display("FAIL areset_pre got cnt=%0d stg=%0d want 3 2", cnt, stage_cnt);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (cnt !== '0 || tick !== 1'b0 || stage_cnt !== '0 ||
        stage_wrap !== 1'b0 || mod_cur !== W'(DM)) begin
      bad++;
      $display("FAIL areset got cnt=%0d tick=%b stg=%0d sw=%b mod=%0d want 0 0 0 0 %0d",
               cnt, tick, stage_cnt, stage_wrap, mod_cur, DM);
    end
    @(posedge pixel_clk);
    #1;
    reset = 1'b0;
    en = 0;
    model_reset();
  endtask

  task automatic test_mod_zero_one();
    do_reset();
    en = 1; mod_wr = 1; mod_in = '0;
    step();
    mod_wr = 0;
    repeat (4) step();
    total++;
    if (cnt !== '0 || mod_cur !== W'(5) || tick !== 1'b1) begin
      bad++;
      $display("FAIL mod_zero got cnt=%0d mod=%0d tick=%b want 0 5 1", cnt, mod_cur, tick);
    end
    mod_wr = 1; mod_in = W'(1);
    step();
    mod_wr = 0; mod_in = '0;
    repeat (4) step();
    for (int i = 0; i < 6; i++) begin
      total++;
      if (cnt !== '0 || tick !== 1'b1 || mod_cur !== W'(1) ||
          stage_cnt !== SW'(m_stage) || stage_wrap !== m_swrap) begin
        bad++;
        $display("FAIL mod_one i=%0d got cnt=%0d tick=%b mod=%0d stg=%0d sw=%b want 0 1 1 %0d %b",
                 i, cnt, tick, mod_cur, stage_cnt, stage_wrap, m_stage, m_swrap);
      end
      step();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      en = ($urandom_range(3) != 0);
      clr = ($urandom_range(24) == 0);
      if ($urandom_range(19) == 0) dir_down = ~dir_down;
      mod_wr = ($urandom_range(7) == 0);
      mod_in = W'($urandom_range(9));
      step();
      total++;
      if (cnt !== W'(m_cnt) || tick !== m_tick || mod_cur !== W'(m_mod) ||
          stage_cnt !== SW'(m_stage) || stage_wrap !== m_swrap) begin
        bad++;
        $display("FAIL random i=%0d got cnt=%0d tick=%b mod=%0d stg=%0d sw=%b want %0d %b %0d %0d %b",
                 i, cnt, tick, mod_cur, stage_cnt, stage_wrap,
                 m_cnt, m_tick, m_mod, m_stage, m_swrap);
      end
    end
    en = 0; clr = 0; mod_wr = 0; dir_down = 0;
  endtask

  initial begin
    reset = 1'b1;
    en = 0; clr = 0; dir_down = 0; mod_wr = 0; mod_in = '0;
    model_reset();
    test_reset();
    test_up_count();
    test_mod_update();
    test_down();
    test_hold_clr();
    test_async_reset();
    test_mod_zero_one();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
